clint_access_unit: RTL and testbench



---
 rtl/clint_access_unit.sv | 172 +++++++++++++++++
 tb/tb_clint_access_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/clint_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : clint_access_unit
// Purpose  : Core-side initiator for the CLINT memory-mapped register port.
//            Accepts LSU load/store requests, decodes the CLINT address
//            window, runs CLINT reads/writes (read-modify-write for sub-word
//            stores) and returns a response. Also registers the CLINT
//            machine-timer interrupt for the CSR unit.
// Ports    : i_clk, i_rst            clock, async active-high reset
//            i_req_*, o_req_ready    LSU request channel (valid/ready)
//            o_resp_*, i_resp_ready  LSU response channel (valid/ready)
//            o_clint_*, i_clint_rdata CLINT MMR port (word-aligned offset)
//            i_clint_mtip, o_mtip    timer interrupt in / registered out
// Revision : 1.0 - initial release
// ============================================================================
module clint_access_unit #(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] CLINT_BASE     = 32'h0200_0000,
    parameter logic [XLEN-1:0] CLINT_MEM_SIZE = 32'h0000_C000,
    localparam int             AW             = $clog2(CLINT_MEM_SIZE)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic            i_req_we,
    input  logic [3:0]      i_req_be,
    input  logic [XLEN-1:0] i_req_wdata,
    output logic            o_resp_valid,
    input  logic            i_resp_ready,
    output logic [XLEN-1:0] o_resp_rdata,
    output logic            o_resp_err,
    output logic [AW-1:0]   o_clint_addr,
    output logic            o_clint_we,
    output logic [XLEN-1:0] o_clint_wdata,
    input  logic [XLEN-1:0] i_clint_rdata,
    input  logic            i_clint_mtip,
    output logic            o_mtip
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam logic [XLEN-1:0] C_END = CLINT_BASE + CLINT_MEM_SIZE;

    logic [2:0]      state_q, state_d;
    logic            we_q;
    logic [3:0]      be_q;
    logic            err_q;
    logic [XLEN-1:0] data_q;      // store data at accept, then read/merged word
    logic [AW-1:0]   clint_addr_q;
    logic            mtip_q;

    logic [XLEN-1:0] w_off;
    logic            w_err;
    logic            w_accept;
    logic [XLEN-1:0] w_merged;

    assign w_off    = i_req_addr - CLINT_BASE;
    assign w_err    = (i_req_addr < CLINT_BASE) || (i_req_addr >= C_END) ||
                      (i_req_be == 4'b0000);
    assign w_accept = i_req_valid && (state_q == S_IDLE);

    // Only the in-window word offset bits are meaningful.
    logic w_unused_off;
    assign w_unused_off = &{1'b0, w_off[XLEN-1:AW], w_off[1:0]};

    // Byte merge for sub-word stores: enabled lanes from the store data,
    // the rest from the word just read back from the CLINT.
    always_comb begin
        w_merged = i_clint_rdata;
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
                w_merged[8*i +: 8] = data_q[8*i +: 8];
            end
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_err) begin
                        state_d = S_RESP;
                    end else if (i_req_we && (i_req_be == 4'b1111)) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;   // loads and partial stores read first
                    end
                end
            end
            S_RD:   state_d = S_CAP;
            S_CAP:  state_d = we_q ? S_WR : S_RESP;
            S_WR:   state_d = S_RESP;
            S_RESP: begin
                if (i_resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_req_ready   = (state_q == S_IDLE);
        o_resp_valid  = (state_q == S_RESP);
        o_resp_err    = (state_q == S_RESP) && err_q;
        o_resp_rdata  = '0;
        o_clint_we    = (state_q == S_WR);
        o_clint_wdata = '0;
        if ((state_q == S_RESP) && !we_q && !err_q) begin
            o_resp_rdata = data_q;
        end
        if (state_q == S_WR) begin
            o_clint_wdata = data_q;
        end
    end

    assign o_clint_addr = clint_addr_q;
    assign o_mtip       = mtip_q;

    // ---------------- Datapath registers ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            we_q         <= 1'b0;
            be_q         <= 4'b0000;
            err_q        <= 1'b0;
            data_q       <= '0;
            clint_addr_q <= '0;
        end else begin
            if (w_accept) begin
                we_q   <= i_req_we;
                be_q   <= i_req_be;
                err_q  <= w_err;
                data_q <= i_req_wdata;
                // Erroring requests never touch the CLINT, so the address
                // bus keeps its previous value for them.
                if (!w_err) begin
                    clint_addr_q <= {w_off[AW-1:2], 2'b00};
                end
            end else if (state_q == S_CAP) begin
                data_q <= we_q ? w_merged : i_clint_rdata;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mtip_q <= 1'b0;
        end else begin
            mtip_q <= i_clint_mtip;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clint_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_clint_access_unit
// Purpose  : Directed self-checking bench for clint_access_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clint_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [15:0] clint_addr;
    logic        clint_we;
    logic [31:0] clint_wdata;
    logic [31:0] clint_rdata;
    logic        clint_mtip;
    logic        mtip;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int wr_base;

    clint_access_unit dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_addr    (req_addr),
        .i_req_we      (req_we),
        .i_req_be      (req_be),
        .i_req_wdata   (req_wdata),
        .o_resp_valid  (resp_valid),
        .i_resp_ready  (resp_ready),
        .o_resp_rdata  (resp_rdata),
        .o_resp_err    (resp_err),
        .o_clint_addr  (clint_addr),
        .o_clint_we    (clint_we),
        .o_clint_wdata (clint_wdata),
        .i_clint_rdata (clint_rdata),
        .i_clint_mtip  (clint_mtip),
        .o_mtip        (mtip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count CLINT write strobes seen at clock edges.
    always @(posedge clk) begin
        if (clint_we) wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request at a falling edge; it is accepted on the next rising
    // edge (DUT idle), then valid is dropped.
    task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_we = w; req_be = b; req_wdata = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_be = '0;
        req_wdata = '0; resp_ready = 1'b1; clint_rdata = '0; clint_mtip = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready",  {31'd0, req_ready},  32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_clint_we",   {31'd0, clint_we},   32'd0);
        chk("rst_clint_addr", {16'd0, clint_addr}, 32'd0);
        chk("rst_mtip",       {31'd0, mtip},       32'd0);
        rst = 1'b0;

        // ---- Full store: WR at cycle 1, response at cycle 2 ----
        wr_base = wr_cnt;
        issue(32'h0200_4000, 1'b1, 4'hF, 32'h1234_5678);
        @(negedge clk);
        chk("fs_we",        {31'd0, clint_we},   32'd1);
        chk("fs_addr",      {16'd0, clint_addr}, 32'h0000_4000);
        chk("fs_wdata",     clint_wdata,         32'h1234_5678);
        chk("fs_req_ready", {31'd0, req_ready},  32'd0);
        chk("fs_early_rv",  {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("fs_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("fs_err",        {31'd0, resp_err},   32'd0);
        chk("fs_rdata",      resp_rdata,          32'd0);
        chk("fs_we_off",     {31'd0, clint_we},   32'd0);
        chk("fs_wdata_off",  clint_wdata,         32'd0);
        @(negedge clk);
        chk("fs_idle", {31'd0, req_ready}, 32'd1);
        chk("fs_nwr",  wr_cnt - wr_base,   32'd1);

        // ---- Load from the top word of the window ----
        clint_rdata = 32'hDEAD_BEEF;
        issue(32'h0200_BFF8, 1'b0, 4'hF, 32'h0);
        @(negedge clk);
        chk("ld_addr", {16'd0, clint_addr}, 32'h0000_BFF8);
        chk("ld_we",   {31'd0, clint_we},   32'd0);
        @(negedge clk);
        chk("ld_cap_rv", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("ld_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("ld_rdata",      resp_rdata,          32'hDEAD_BEEF);
        chk("ld_err",        {31'd0, resp_err},   32'd0);

        // ---- Partial store (read-modify-write) ----
        clint_rdata = 32'h1111_1111;
        wr_base = wr_cnt;
        issue(32'h0200_4004, 1'b1, 4'b0100, 32'h00AB_0000);
        @(negedge clk);
        chk("ps_rd_addr", {16'd0, clint_addr}, 32'h0000_4004);
        chk("ps_rd_we",   {31'd0, clint_we},   32'd0);
        @(negedge clk);
        chk("ps_cap_we", {31'd0, clint_we}, 32'd0);
        @(negedge clk);
        chk("ps_we",    {31'd0, clint_we},   32'd1);
        chk("ps_wdata", clint_wdata,         32'h11AB_1111);
        chk("ps_addr",  {16'd0, clint_addr}, 32'h0000_4004);
        @(negedge clk);
        chk("ps_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("ps_rdata",      resp_rdata,          32'd0);
        @(negedge clk);
        chk("ps_nwr", wr_cnt - wr_base, 32'd1);

        // ---- Error cases: response after 1 cycle, no CLINT strobe ----
        wr_base = wr_cnt;
        clint_rdata = 32'hFFFF_FFFF;
        issue(32'h0200_C000, 1'b0, 4'hF, 32'h0);
        @(negedge clk);
        chk("e1_rv",    {31'd0, resp_valid}, 32'd1);
        chk("e1_err",   {31'd0, resp_err},   32'd1);
        chk("e1_rdata", resp_rdata,          32'd0);
        chk("e1_addr_hold", {16'd0, clint_addr}, 32'h0000_4004);
        issue(32'h01FF_FFFC, 1'b1, 4'hF, 32'hAAAA_AAAA);
        @(negedge clk);
        chk("e2_rv",  {31'd0, resp_valid}, 32'd1);
        chk("e2_err", {31'd0, resp_err},   32'd1);
        chk("e2_we",  {31'd0, clint_we},   32'd0);
        issue(32'h0200_0000, 1'b1, 4'h0, 32'h5555_5555);
        @(negedge clk);
        chk("e3_rv",    {31'd0, resp_valid}, 32'd1);
        chk("e3_err",   {31'd0, resp_err},   32'd1);
        chk("e3_rdata", resp_rdata,          32'd0);
        @(negedge clk);
        chk("err_nwr", wr_cnt - wr_base, 32'd0);

        // ---- Response back-pressure; queued request waits for handshake ----
        resp_ready = 1'b0;
        clint_rdata = 32'hCAFE_F00D;
        issue(32'h0200_0010, 1'b0, 4'hF, 32'h0);
        repeat (3) @(negedge clk);
        // Present the next request while the response is still pending.
        req_valid = 1'b1; req_addr = 32'h0200_0020; req_we = 1'b1;
        req_be = 4'hF; req_wdata = 32'h0000_0055;
        clint_rdata = 32'h0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_rv",    {31'd0, resp_valid}, 32'd1);
            chk("bp_rdata", resp_rdata,          32'hCAFE_F00D);
            chk("bp_ready", {31'd0, req_ready},  32'd0);
            chk("bp_we",    {31'd0, clint_we},   32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_rv",    {31'd0, resp_valid}, 32'd0);
        chk("bp_hs_ready", {31'd0, req_ready},  32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_we",   {31'd0, clint_we},   32'd1);
        chk("bp_next_addr", {16'd0, clint_addr}, 32'h0000_0020);
        @(negedge clk);
        chk("bp_next_rv", {31'd0, resp_valid}, 32'd1);
        @(negedge clk);

        // ---- Reset while in WR ----
        issue(32'h0200_0030, 1'b1, 4'hF, 32'h7777_7777);
        @(negedge clk);
        chk("rw_we_before", {31'd0, clint_we}, 32'd1);
        wr_base = wr_cnt;
        #1 rst = 1'b1;
        #1;
        chk("rw_we",    {31'd0, clint_we},   32'd0);
        chk("rw_rv",    {31'd0, resp_valid}, 32'd0);
        chk("rw_ready", {31'd0, req_ready},  32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rw_nwr", wr_cnt - wr_base, 32'd0);
        chk("rw_rv_after", {31'd0, resp_valid}, 32'd0);

        // ---- mtip registered with one cycle of lag ----
        @(negedge clk);
        clint_mtip = 1'b1;
        #1;
        chk("mtip_lag", {31'd0, mtip}, 32'd0);
        @(posedge clk);
        #1;
        chk("mtip_rise", {31'd0, mtip}, 32'd1);
        @(negedge clk);
        clint_mtip = 1'b0;
        @(posedge clk);
        #1;
        chk("mtip_fall", {31'd0, mtip}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
